alarm_timekeeper: RTL and testbench
===================================

# alarm_timekeeper

Parametrised time-of-day core with N independent alarms and snooze. It replaces the gated-clock minute/second counter and controller pair with a single-clock, clock-enable design. It tracks HH:MM:SS in 24-hour format, handles time/alarm setting from debounced single-cycle button pulses, and produces ring status for the buzzer. It sits between the debounce stage and the digit-split/FND display path.

## Interface

Parameters:
- CLK_HZ, 50_000_000, input clock frequency; one second = CLK_HZ cycles.
- NUM_ALARM, 4, number of alarm channels (1..16).
- SNOOZE_MIN, 5, snooze duration in minutes.
- RING_SEC, 60, ring auto-timeout in seconds.
- ALM_W, derived as max(1, $clog2(NUM_ALARM)); not user-set.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_mode_step  in  1  pulse: mode RUN→SET_TIME→SET_ALARM→RUN.
- i_pos_step  in  1  pulse: field SEC→MIN→HOUR→SEC.
- i_inc  in  1  pulse: increment the selected field.
- i_alm_sel_step  in  1  pulse: next alarm index, wraps at NUM_ALARM-1.
- i_alm_en_toggle  in  1  pulse: toggle enable of the selected alarm.
- i_snooze  in  1  pulse: snooze the ringing alarm.
- i_stop  in  1  pulse: silence the ringing alarm.
- o_sec  out  6  displayed seconds.
- o_min  out  6  displayed minutes.
- o_hour  out  5  displayed hours.
- o_mode  out  2  0 RUN, 1 SET_TIME, 2 SET_ALARM.
- o_pos  out  2  0 SEC, 1 MIN, 2 HOUR.
- o_alm_sel  out  ALM_W  selected alarm.
- o_alm_en  out  NUM_ALARM  per-alarm enable.
- o_ring  out  1  buzzer enable.
- o_ring_id  out  ALM_W  index of the ringing or snoozed alarm.
- o_tick  out  1  one-cycle pulse per elapsed second.

## Operation

**Reset values**
- Time and all alarms: 00:00:00.
- o_alm_en: all 0.
- Mode RUN, pos SEC, sel 0.
- o_ring, o_ring_id, o_tick: all 0.
- Prescaler 0, ring FSM IDLE.

**Prescaler**
- Counts 0..CLK_HZ-1. The wrap cycle is the tick.
- Runs in RUN and SET_ALARM.
- Held at 0 in SET_TIME. Leaving SET_TIME therefore gives a full second before the next tick.

**Time counter**
- On tick: sec+1. At 59→0, min carries; at 59→0, hour carries; at 23→0.
- 23:59:59 wraps to 00:00:00.

**Setting**
- i_inc in SET_TIME increments the time field selected by o_pos.
- i_inc in SET_ALARM increments the same field of alarm o_alm_sel.
- Each field wraps at its own max (59/59/23) with no carry.
- i_alm_sel_step and i_alm_en_toggle act only in SET_ALARM. i_pos_step acts only in the SET modes.
- Pulses arriving in any other mode are ignored.
- Leaving SET_ALARM resets o_pos to SEC.

**Display mux**
- SET_ALARM shows alarm o_alm_sel.
- RUN and SET_TIME show the time.

**Match**
- An alarm matches when it is enabled, mode ≠ SET_TIME, and its HH:MM:SS equals the current time.
- Evaluated only in the cycle after a tick.
- If several alarms match, the lowest index wins.

**Ring FSM (IDLE, RING, SNOOZE)**
- IDLE→RING on match: latch o_ring_id, load the timeout counter with RING_SEC.
- RING:
  - i_stop → IDLE.
  - i_snooze → SNOOZE, load countdown with SNOOZE_MIN*60.
  - Timeout counter reaches 0 on a tick → IDLE.
- SNOOZE: countdown reaches 0 on a tick → RING (same id, timeout reloaded). i_stop → IDLE.
- i_stop and i_snooze in the same cycle: stop wins.
- Clearing the enable of o_ring_id while in RING or SNOOZE → IDLE.
- Matches arriving in RING or SNOOZE are ignored.
- Changing mode does not affect the ring FSM, but SNOOZE countdown ticks are paused while in SET_TIME.
- o_ring = 1 only in RING.

## Timing

- o_tick is registered. It is high in the first cycle the incremented time is visible on the outputs.
- o_ring rises 1 cycle after o_tick for a matching second, i.e. 2 edges after the prescaler wrap.
- A control pulse sampled at edge k has its effect visible after edge k (1-cycle latency). No handshake.
- Input pulses longer than one cycle act once per high cycle. Upstream delivers single-cycle pulses.
- Reset asserted mid-ring: o_ring drops immediately (asynchronously); all state returns to reset values.

## Structure

- Package alarm_timekeeper_pkg holds:
  - mode_e, pos_e and ring_state_e enums.
  - Constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - An hms_t struct (hour 5b, min 6b, sec 6b).
- Sub-module sec_tick_gen (parameter CLK_HZ; ports clk, rst_n, i_hold, o_tick) implements the prescaler.
- Alarms are stored as an array of hms_t, NUM_ALARM deep.
- Ring timeout and snooze countdown share one down-counter sized for max(RING_SEC, SNOOZE_MIN*60).

## Test plan

All scenarios use CLK_HZ=4.

1. Reset then 240 cycles → o_sec=0, o_min=1, exactly 60 o_tick pulses. Preload 23:59:59 via SET_TIME, return to RUN, wait 4 cycles → 00:00:00.
2. mode_step once, pos_step twice, 25×inc → o_hour=1, o_pos=2. Hold 40 cycles in SET_TIME → time unchanged, o_tick never high.
3. Set alarm 0 to 00:00:03 and enable it, return to RUN at 00:00:00 → o_ring=1, o_ring_id=0, one cycle after the 3rd tick. i_stop → o_ring=0 next cycle.
4. Alarms 1 and 2 both 00:00:02 and enabled, alarm 0 disabled → o_ring_id=1. Same-cycle i_stop+i_snooze → IDLE, no re-ring.
5. SNOOZE_MIN=1 with an alarm ringing: i_snooze → o_ring=0, re-rings exactly 60 ticks later with the same id. RING_SEC=5 with no response → o_ring clears after 5 ticks.
6. rst_n pulled low while o_ring=1 → o_ring=0 with no clock edge. After release, all outputs are at reset values.

Source files
------------

// File: rtl/alarm_timekeeper_pkg.sv
// Shared types and time-of-day helpers for the alarm timekeeper.
// Fields wrap independently when set by hand; the running clock carries between them.
package alarm_timekeeper_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2
    } pos_e;

    typedef enum logic [1:0] {
        RS_IDLE   = 2'd0,
        RS_RING   = 2'd1,
        RS_SNOOZE = 2'd2
    } ring_state_e;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } hms_t;

    // One elapsed second with full carry chain; 23:59:59 rolls to 00:00:00.
    function automatic hms_t hms_tick(input hms_t t);
        hms_t r;
        r = t;
        if (t.sec == SEC_MAX) begin
            r.sec = '0;
            if (t.min == MIN_MAX) begin
                r.min  = '0;
                r.hour = (t.hour == HOUR_MAX) ? 5'd0 : t.hour + 5'd1;
            end else begin
                r.min = t.min + 6'd1;
            end
        end else begin
            r.sec = t.sec + 6'd1;
        end
        return r;
    endfunction

    function automatic hms_t hms_inc_field(input hms_t t, input pos_e p);
        hms_t r;
        r = t;
        case (p)
            POS_SEC:  r.sec  = (t.sec  == SEC_MAX)  ? 6'd0 : t.sec  + 6'd1;
            POS_MIN:  r.min  = (t.min  == MIN_MAX)  ? 6'd0 : t.min  + 6'd1;
            POS_HOUR: r.hour = (t.hour == HOUR_MAX) ? 5'd0 : t.hour + 5'd1;
            default:  r = t;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alarm_timekeeper_sec_tick_gen.sv
// One-second prescaler. o_tick flags the wrap cycle combinationally so the
// parent can advance time and register its own tick on the same edge.
module sec_tick_gen #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_hold,
    output logic o_tick
);
    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    assign wrap   = (cnt_q == LAST);
    assign o_tick = wrap && !i_hold;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_hold || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alarm_timekeeper.sv
// 24-hour time-of-day core with NUM_ALARM alarms, manual setting modes and a
// ring/snooze controller driving the buzzer enable.
module alarm_timekeeper
    import alarm_timekeeper_pkg::*;
#(
    parameter  int CLK_HZ     = 50_000_000,
    parameter  int NUM_ALARM  = 4,
    parameter  int SNOOZE_MIN = 5,
    parameter  int RING_SEC   = 60,
    localparam int ALM_W      = (NUM_ALARM > 1) ? $clog2(NUM_ALARM) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_mode_step,
    input  logic                 i_pos_step,
    input  logic                 i_inc,
    input  logic                 i_alm_sel_step,
    input  logic                 i_alm_en_toggle,
    input  logic                 i_snooze,
    input  logic                 i_stop,
    output logic [5:0]           o_sec,
    output logic [5:0]           o_min,
    output logic [4:0]           o_hour,
    output logic [1:0]           o_mode,
    output logic [1:0]           o_pos,
    output logic [ALM_W-1:0]     o_alm_sel,
    output logic [NUM_ALARM-1:0] o_alm_en,
    output logic                 o_ring,
    output logic [ALM_W-1:0]     o_ring_id,
    output logic                 o_tick
);
    localparam int SNOOZE_SEC = SNOOZE_MIN * 60;
    localparam int CNT_MAX    = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SEC);
    localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SEC);

    mode_e                mode_q, mode_d;
    pos_e                 pos_q, pos_d;
    logic [ALM_W-1:0]     sel_q, sel_d;
    logic [NUM_ALARM-1:0] en_q, en_d;
    hms_t                 time_q, time_d;
    hms_t                 alarm_q [NUM_ALARM];
    logic                 tick_w;
    logic                 tick_q;

    ring_state_e          ring_state_q;
    logic [ALM_W-1:0]     ring_id_q;
    logic [CNT_W-1:0]     ring_cnt_q;
    logic                 ring_q;

    logic                 set_time;
    logic                 set_alarm;
    logic [NUM_ALARM-1:0] hit;
    logic [ALM_W-1:0]     match_idx;
    logic                 match_any;
    logic                 ring_cancel;
    hms_t                 disp;

    assign set_time  = (mode_q == MODE_SET_TIME);
    assign set_alarm = (mode_q == MODE_SET_ALARM);

    sec_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_hold (set_time),
        .o_tick (tick_w)
    );

    always_comb begin
        mode_d = mode_q;
        pos_d  = pos_q;
        sel_d  = sel_q;
        en_d   = en_q;
        time_d = time_q;

        if (i_pos_step && mode_q != MODE_RUN) begin
            case (pos_q)
                POS_SEC: pos_d = POS_MIN;
                POS_MIN: pos_d = POS_HOUR;
                default: pos_d = POS_SEC;
            endcase
        end
        if (i_mode_step) begin
            case (mode_q)
                MODE_RUN:      mode_d = MODE_SET_TIME;
                MODE_SET_TIME: mode_d = MODE_SET_ALARM;
                default: begin
                    mode_d = MODE_RUN;
                    pos_d  = POS_SEC;
                end
            endcase
        end

        if (set_alarm && i_alm_sel_step) begin
            sel_d = (sel_q == ALM_W'(NUM_ALARM - 1)) ? '0 : sel_q + ALM_W'(1);
        end
        if (set_alarm && i_alm_en_toggle) begin
            en_d[sel_q] = ~en_q[sel_q];
        end

        // The prescaler is frozen in SET_TIME, so a tick and a manual edit never collide.
        if (tick_w) begin
            time_d = hms_tick(time_q);
        end else if (set_time && i_inc) begin
            time_d = hms_inc_field(time_q, pos_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_RUN;
            pos_q  <= POS_SEC;
            sel_q  <= '0;
            en_q   <= '0;
            time_q <= '0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            pos_q  <= pos_d;
            sel_q  <= sel_d;
            en_q   <= en_d;
            time_q <= time_d;
            tick_q <= tick_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ALARM; i++) begin
                alarm_q[i] <= '0;
            end
        end else if (set_alarm && i_inc) begin
            alarm_q[sel_q] <= hms_inc_field(alarm_q[sel_q], pos_q);
        end
    end

    for (genvar gi = 0; gi < NUM_ALARM; gi++) begin : g_hit
        assign hit[gi] = en_q[gi] && (alarm_q[gi] == time_q);
    end

    always_comb begin
        match_idx = '0;
        for (int i = NUM_ALARM - 1; i >= 0; i--) begin
            if (hit[i]) begin
                match_idx = ALM_W'(i);
            end
        end
    end

    // Compared one cycle after the tick, once time_q already shows the new second.
    assign match_any   = tick_q && !set_time && (|hit);
    assign ring_cancel = i_stop || !en_d[ring_id_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_state_q <= RS_IDLE;
            ring_id_q    <= '0;
            ring_cnt_q   <= '0;
            ring_q       <= 1'b0;
        end else begin
            case (ring_state_q)
                RS_IDLE: begin
                    if (match_any) begin
                        ring_state_q <= RS_RING;
                        ring_id_q    <= match_idx;
                        ring_cnt_q   <= RING_LOAD;
                        ring_q       <= 1'b1;
                    end
                end
                RS_RING: begin
                    if (ring_cancel) begin
                        ring_state_q <= RS_IDLE;
                        ring_q       <= 1'b0;
                    end else if (i_snooze) begin
                        ring_state_q <= RS_SNOOZE;
                        ring_cnt_q   <= SNOOZE_LOAD;
                        ring_q       <= 1'b0;
                    end else if (tick_w) begin
                        if (ring_cnt_q <= CNT_W'(1)) begin
                            ring_state_q <= RS_IDLE;
                            ring_q       <= 1'b0;
                        end else begin
                            ring_cnt_q <= ring_cnt_q - CNT_W'(1);
                        end
                    end
                end
                RS_SNOOZE: begin
                    if (ring_cancel) begin
                        ring_state_q <= RS_IDLE;
                    end else if (tick_w) begin
                        if (ring_cnt_q <= CNT_W'(1)) begin
                            ring_state_q <= RS_RING;
                            ring_cnt_q   <= RING_LOAD;
                            ring_q       <= 1'b1;
                        end else begin
                            ring_cnt_q <= ring_cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    ring_state_q <= RS_IDLE;
                    ring_q       <= 1'b0;
                end
            endcase
        end
    end

    assign disp      = set_alarm ? alarm_q[sel_q] : time_q;
    assign o_sec     = disp.sec;
    assign o_min     = disp.min;
    assign o_hour    = disp.hour;
    assign o_mode    = mode_q;
    assign o_pos     = pos_q;
    assign o_alm_sel = sel_q;
    assign o_alm_en  = en_q;
    assign o_ring    = ring_q;
    assign o_ring_id = ring_id_q;
    assign o_tick    = tick_q;

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Randomized and directed bench for alarm_timekeeper against a seconds-of-day
// reference model; all outputs are compared every cycle.
module tb_alarm_timekeeper;
    localparam int HZ  = 4;
    localparam int NA  = 4;
    localparam int SNZ = 1;
    localparam int RS  = 5;
    localparam int AW  = 2;

    localparam bit [6:0] P_MODE = 7'b0000001;
    localparam bit [6:0] P_POS  = 7'b0000010;
    localparam bit [6:0] P_INC  = 7'b0000100;
    localparam bit [6:0] P_SEL  = 7'b0001000;
    localparam bit [6:0] P_EN   = 7'b0010000;
    localparam bit [6:0] P_SNZ  = 7'b0100000;
    localparam bit [6:0] P_STOP = 7'b1000000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mode_step = 0, pos_step = 0, inc = 0, sel_step = 0, en_tog = 0, snooze = 0, stop = 0;
    logic [5:0]    o_sec, o_min;
    logic [4:0]    o_hour;
    logic [1:0]    o_mode, o_pos;
    logic [AW-1:0] o_alm_sel, o_ring_id;
    logic [NA-1:0] o_alm_en;
    logic          o_ring, o_tick;

    alarm_timekeeper #(
        .CLK_HZ     (HZ),
        .NUM_ALARM  (NA),
        .SNOOZE_MIN (SNZ),
        .RING_SEC   (RS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_mode_step     (mode_step),
        .i_pos_step      (pos_step),
        .i_inc           (inc),
        .i_alm_sel_step  (sel_step),
        .i_alm_en_toggle (en_tog),
        .i_snooze        (snooze),
        .i_stop          (stop),
        .o_sec           (o_sec),
        .o_min           (o_min),
        .o_hour          (o_hour),
        .o_mode          (o_mode),
        .o_pos           (o_pos),
        .o_alm_sel       (o_alm_sel),
        .o_alm_en        (o_alm_en),
        .o_ring          (o_ring),
        .o_ring_id       (o_ring_id),
        .o_tick          (o_tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: time and alarms as seconds-of-day, ring state as 0 idle / 1 ring / 2 snooze.
    int m_tod, m_mode, m_pos, m_sel, m_pre, m_rs, m_id, m_cnt;
    int m_alm [NA];
    bit [NA-1:0] m_en;
    bit m_tick;
    int ticks_seen;

    function automatic logic [16:0] enc(input int tod);
        logic [4:0] h;
        logic [5:0] mi, s;
        h  = 5'(tod / 3600);
        mi = 6'((tod / 60) % 60);
        s  = 6'(tod % 60);
        return {h, mi, s};
    endfunction

    function automatic int fld(input int tod, input int p);
        if (p == 0) return tod % 60;
        if (p == 1) return (tod / 60) % 60;
        return tod / 3600;
    endfunction

    function automatic int bump(input int tod, input int p);
        int h, mi, s;
        h = tod / 3600; mi = (tod / 60) % 60; s = tod % 60;
        if (p == 0) s = (s + 1) % 60;
        else if (p == 1) mi = (mi + 1) % 60;
        else h = (h + 1) % 24;
        return h * 3600 + mi * 60 + s;
    endfunction

    task automatic model_reset();
        m_tod = 0; m_mode = 0; m_pos = 0; m_sel = 0; m_pre = 0;
        m_rs = 0; m_id = 0; m_cnt = 0; m_en = '0; m_tick = 0;
        for (int i = 0; i < NA; i++) m_alm[i] = 0;
    endtask

    task automatic model_step(input bit [6:0] p);
        bit wrap;
        int n_tod, n_mode, n_pos, n_sel, n_pre, n_rs, n_id, n_cnt, first;
        bit [NA-1:0] n_en;
        wrap  = (m_mode != 1) && (m_pre == HZ - 1);
        n_pre = (m_mode == 1) ? 0 : (m_pre + 1) % HZ;
        n_en  = m_en;
        if (m_mode == 2 && p[4]) n_en[m_sel] = !m_en[m_sel];
        n_tod = m_tod;
        if (wrap) n_tod = (m_tod + 1) % 86400;
        else if (m_mode == 1 && p[2]) n_tod = bump(m_tod, m_pos);
        n_sel = m_sel;
        if (m_mode == 2 && p[3]) n_sel = (m_sel + 1) % NA;
        n_pos = m_pos;
        if (m_mode != 0 && p[1]) n_pos = (m_pos + 1) % 3;
        n_mode = m_mode;
        if (p[0]) begin
            n_mode = (m_mode + 1) % 3;
            if (m_mode == 2) n_pos = 0;
        end
        n_rs = m_rs; n_id = m_id; n_cnt = m_cnt;
        if (m_rs == 0) begin
            first = -1;
            if (m_tick && m_mode != 1)
                for (int i = 0; i < NA; i++)
                    if (first < 0 && m_en[i] && m_alm[i] == m_tod) first = i;
            if (first >= 0) begin n_rs = 1; n_id = first; n_cnt = RS; end
        end else if (p[6] || !n_en[m_id]) begin
            n_rs = 0;
        end else if (m_rs == 1 && p[5]) begin
            n_rs = 2; n_cnt = SNZ * 60;
        end else if (wrap) begin
            n_cnt = m_cnt - 1;
            if (n_cnt == 0) begin
                if (m_rs == 1) n_rs = 0;
                else begin n_rs = 1; n_cnt = RS; end
            end
        end
        if (m_mode == 2 && p[2]) m_alm[m_sel] = bump(m_alm[m_sel], m_pos);
        m_tod = n_tod; m_mode = n_mode; m_pos = n_pos; m_sel = n_sel; m_pre = n_pre;
        m_en = n_en; m_rs = n_rs; m_id = n_id; m_cnt = n_cnt; m_tick = wrap;
    endtask

    task automatic compare_all();
        logic [16:0] dexp;
        dexp = (m_mode == 2) ? enc(m_alm[m_sel]) : enc(m_tod);
        chk("disp", {o_hour, o_min, o_sec}, dexp);
        chk("mode_pos", {o_mode, o_pos}, {m_mode[1:0], m_pos[1:0]});
        chk("alm_sel", o_alm_sel, m_sel);
        chk("alm_en", o_alm_en, m_en);
        chk("ring", o_ring, (m_rs == 1));
        chk("ring_id", o_ring_id, m_id);
        chk("tick", o_tick, m_tick);
    endtask

    task automatic step(input bit [6:0] p);
        {stop, snooze, en_tog, sel_step, inc, pos_step, mode_step} = p;
        @(posedge clk);
        model_step(p);
        @(negedge clk);
        {stop, snooze, en_tog, sel_step, inc, pos_step, mode_step} = '0;
        compare_all();
        if (o_tick) ticks_seen++;
    endtask

    task automatic goto_mode(input int m);
        for (int k = 0; k < 3 && m_mode != m; k++) step(P_MODE);
    endtask

    task automatic goto_pos(input int p);
        for (int k = 0; k < 3 && m_pos != p; k++) step(P_POS);
    endtask

    task automatic sel_to(input int a);
        for (int k = 0; k < NA && m_sel != a; k++) step(P_SEL);
    endtask

    task automatic en_to(input int a, input bit v);
        sel_to(a);
        if (m_en[a] != v) step(P_EN);
    endtask

    task automatic inc_to(input int target);
        int cur, md, n;
        cur = (m_mode == 1) ? fld(m_tod, m_pos) : fld(m_alm[m_sel], m_pos);
        md  = (m_pos == 2) ? 24 : 60;
        n   = (target - cur + md) % md;
        repeat (n) step(P_INC);
    endtask

    task automatic set_hms(input int h, input int mi, input int s);
        goto_pos(2); inc_to(h);
        goto_pos(1); inc_to(mi);
        goto_pos(0); inc_to(s);
    endtask

    task automatic time_zero_and_run();
        goto_mode(1);
        set_hms(0, 0, 0);
        step(P_MODE);
        step(P_MODE);
    endtask

    task automatic wait_ring(input int limit, output int nt, output bit prev, output bit seen);
        nt = 0; prev = 0; seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            prev = o_tick;
            step('0);
            if (o_tick) nt++;
            if (o_ring) seen = 1;
        end
    endtask

    task automatic wait_noring(input int limit, output int nt, output bit seen);
        nt = 0; seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            step('0);
            if (o_tick) nt++;
            if (!o_ring) seen = 1;
        end
    endtask

    initial begin
        int nt, rc;
        bit prev, seen;
        logic [16:0] snap;
        bit [6:0] p;

        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        chk("rst_time", {o_hour, o_min, o_sec}, 17'd0);
        chk("rst_ring", o_ring, 1'b0);

        ticks_seen = 0;
        repeat (240) step('0);
        chk("t1_sec", o_sec, 6'd0);
        chk("t1_min", o_min, 6'd1);
        chk("t1_ticks", ticks_seen, 60);
        goto_mode(1);
        set_hms(23, 59, 59);
        step(P_MODE);
        step(P_MODE);
        repeat (3) step('0);
        chk("t1_wrap", {o_hour, o_min, o_sec}, 17'd0);
        chk("t1_wrap_tick", o_tick, 1'b1);
        $display("scenario 1: free run and midnight wrap checked");

        step(P_MODE);
        step(P_POS);
        step(P_POS);
        repeat (25) step(P_INC);
        chk("t2_hour", o_hour, 5'd1);
        chk("t2_pos", o_pos, 2'd2);
        snap = enc(m_tod);
        ticks_seen = 0;
        repeat (40) step('0);
        chk("t2_hold", {o_hour, o_min, o_sec}, snap);
        chk("t2_noticks", ticks_seen, 0);
        $display("scenario 2: set hour 1 and hold in SET_TIME");

        goto_mode(2);
        sel_to(0);
        set_hms(0, 0, 3);
        en_to(0, 1);
        time_zero_and_run();
        wait_ring(40, nt, prev, seen);
        chk("t3_seen", seen, 1'b1);
        chk("t3_ticks", nt, 3);
        chk("t3_prev_tick", prev, 1'b1);
        chk("t3_id", o_ring_id, 0);
        step(P_STOP);
        chk("t3_stop", o_ring, 1'b0);
        $display("scenario 3: alarm 0 at 00:00:03 rang after %0d ticks", nt);

        goto_mode(2);
        en_to(0, 0);
        sel_to(1); set_hms(0, 0, 2); en_to(1, 1);
        sel_to(2); set_hms(0, 0, 2); en_to(2, 1);
        time_zero_and_run();
        wait_ring(40, nt, prev, seen);
        chk("t4_seen", seen, 1'b1);
        chk("t4_id", o_ring_id, 1);
        step(P_STOP | P_SNZ);
        chk("t4_stop", o_ring, 1'b0);
        rc = 0;
        repeat (300) begin
            step('0);
            if (o_ring) rc++;
        end
        chk("t4_no_rering", rc, 0);
        $display("scenario 4: lowest index wins, stop beats snooze");

        time_zero_and_run();
        wait_ring(40, nt, prev, seen);
        chk("t5_seen", seen, 1'b1);
        step(P_SNZ);
        chk("t5_snoozed", o_ring, 1'b0);
        wait_ring(400, nt, prev, seen);
        chk("t5_rering", seen, 1'b1);
        chk("t5_snz_ticks", nt, 60);
        chk("t5_id", o_ring_id, 1);
        wait_noring(100, nt, seen);
        chk("t5_timeout", seen, 1'b1);
        chk("t5_to_ticks", nt, RS);
        $display("scenario 5: snooze re-ring and ring timeout");

        time_zero_and_run();
        wait_ring(40, nt, prev, seen);
        chk("t6_seen", seen, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_async", o_ring, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        chk("t6_id", o_ring_id, 0);
        chk("t6_en", o_alm_en, 4'd0);
        chk("t6_mode", {o_mode, o_pos, o_alm_sel}, 6'd0);
        $display("scenario 6: async reset during ring");

        repeat (2500) begin
            p = '0;
            if ($urandom_range(199) == 0) p |= P_MODE;
            if ($urandom_range(19) == 0)  p |= P_POS;
            if ($urandom_range(5) == 0)   p |= P_INC;
            if ($urandom_range(19) == 0)  p |= P_SEL;
            if ($urandom_range(14) == 0)  p |= P_EN;
            if ($urandom_range(99) == 0)  p |= P_SNZ;
            if ($urandom_range(149) == 0) p |= P_STOP;
            step(p);
        end
        $display("scenario 7: random pulses, time=%02d:%02d:%02d", o_hour, o_min, o_sec);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
